ctrl_pipe: RTL

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe_if.sv | 37 +++
 rtl/ctrl_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_if.sv
// Handshake bundle between the fetch/decode stage and the EX/WB control
// pipeline. The decode side drives the instruction fields and flush; the
// control pipeline returns the stall request and the registered EX/WB controls.
interface ctrl_pipe_if #(
    parameter int NUM_CSR = 2
);
    logic               instr_valid;
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [11:0]        imm12;
    logic               flush;

    logic               stall_FD;
    logic               valid_EX;
    logic               regwrite_EX;
    logic [1:0]         alusrc_EX;
    logic [1:0]         regsel_EX;
    logic [3:0]         aluop_EX;
    logic               div_unsigned_EX;
    logic               illegal_EX;
    logic [NUM_CSR-1:0] csr_we_EX;
    logic               regwrite_WB;
    logic [1:0]         regsel_WB;

    modport master (
        output instr_valid, op, funct3, funct7, imm12, flush,
        input  stall_FD, valid_EX, regwrite_EX, alusrc_EX, regsel_EX, aluop_EX,
               div_unsigned_EX, illegal_EX, csr_we_EX, regwrite_WB, regsel_WB
    );

    modport slave (
        input  instr_valid, op, funct3, funct7, imm12, flush,
        output stall_FD, valid_EX, regwrite_EX, alusrc_EX, regsel_EX, aluop_EX,
               div_unsigned_EX, illegal_EX, csr_we_EX, regwrite_WB, regsel_WB
    );
endinterface

// File: rtl/ctrl_pipe.sv
// Decode-to-EX control pipeline. Decodes RV32IM ALU ops, LUI/AUIPC and CSRRW
// to CSR-mapped GPIO registers, registers the controls into EX and WB, and
// holds a divide in EX for DIV_CYCLES cycles while stalling fetch/decode.
module ctrl_pipe #(
    parameter int          NUM_CSR    = 2,
    parameter logic [11:0] CSR_BASE   = 12'hF00,
    parameter int          CSR_STRIDE = 2,
    parameter int          DIV_CYCLES = 33
) (
    input logic         clk,
    input logic         rst,
    ctrl_pipe_if.slave  bus
);

    localparam int CW = $clog2(DIV_CYCLES);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_XOR    = 4'b0001;
    localparam logic [3:0] ALU_OR     = 4'b0010;
    localparam logic [3:0] ALU_ADD    = 4'b0011;
    localparam logic [3:0] ALU_SUB    = 4'b0100;
    localparam logic [3:0] ALU_SLL    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_SLT    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_MUL    = 4'b1010;
    localparam logic [3:0] ALU_MULH   = 4'b1011;
    localparam logic [3:0] ALU_MULHSU = 4'b1100;
    localparam logic [3:0] ALU_MULHU  = 4'b1101;
    localparam logic [3:0] ALU_DIV    = 4'b1110;
    localparam logic [3:0] ALU_REM    = 4'b1111;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic [CW-1:0]        count;

    logic                 dec_regwrite;
    logic [1:0]           dec_alusrc;
    logic [1:0]           dec_regsel;
    logic [3:0]           dec_aluop;
    logic                 dec_div_unsigned;
    logic                 dec_illegal;
    logic [NUM_CSR-1:0]   dec_csr_we;
    logic                 dec_is_div;

    // Base integer op shared by R-type (funct7 00h) and I-type; alt_shift picks SRA.
    function automatic logic [3:0] base_aluop(input logic [2:0] f3, input logic alt_shift);
        case (f3)
            3'b000:  base_aluop = ALU_ADD;
            3'b001:  base_aluop = ALU_SLL;
            3'b010:  base_aluop = ALU_SLT;
            3'b011:  base_aluop = ALU_SLTU;
            3'b100:  base_aluop = ALU_XOR;
            3'b101:  base_aluop = alt_shift ? ALU_SRA : ALU_SRL;
            3'b110:  base_aluop = ALU_OR;
            default: base_aluop = ALU_AND;
        endcase
    endfunction

    // M-extension op; funct3[2] marks the divide class, funct3[1] picks REM over DIV.
    function automatic logic [3:0] m_aluop(input logic [2:0] f3);
        case (f3)
            3'b000:  m_aluop = ALU_MUL;
            3'b001:  m_aluop = ALU_MULH;
            3'b010:  m_aluop = ALU_MULHSU;
            3'b011:  m_aluop = ALU_MULHU;
            default: m_aluop = f3[1] ? ALU_REM : ALU_DIV;
        endcase
    endfunction

    // Combinational decode; an empty slot decodes to the bubble defaults.
    always_comb begin
        dec_regwrite     = 1'b0;
        dec_alusrc       = 2'b00;
        dec_regsel       = 2'b00;
        dec_aluop        = ALU_ADD;
        dec_div_unsigned = 1'b0;
        dec_illegal      = 1'b0;
        dec_csr_we       = '0;
        dec_is_div       = 1'b0;
        if (bus.instr_valid) begin
            case (bus.op)
                OP_R: begin
                    if (bus.funct7 == 7'h00) begin
                        dec_regwrite = 1'b1;
                        dec_aluop    = base_aluop(bus.funct3, 1'b0);
                    end else if (bus.funct7 == 7'h20 && bus.funct3 == 3'b000) begin
                        dec_regwrite = 1'b1;
                        dec_aluop    = ALU_SUB;
                    end else if (bus.funct7 == 7'h20 && bus.funct3 == 3'b101) begin
                        dec_regwrite = 1'b1;
                        dec_aluop    = ALU_SRA;
                    end else if (bus.funct7 == 7'h01) begin
                        dec_regwrite     = 1'b1;
                        dec_aluop        = m_aluop(bus.funct3);
                        dec_is_div       = bus.funct3[2];
                        dec_div_unsigned = bus.funct3[2] & bus.funct3[0];
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                OP_I: begin
                    dec_regwrite = 1'b1;
                    dec_alusrc   = 2'b01;
                    dec_aluop    = base_aluop(bus.funct3, bus.funct7 == 7'h20);
                end
                OP_LUI: begin
                    dec_regwrite = 1'b1;
                    dec_regsel   = 2'b10;
                end
                OP_AUIPC: begin
                    dec_regwrite = 1'b1;
                    dec_alusrc   = 2'b11;
                    dec_aluop    = ALU_ADD;
                end
                OP_SYS: begin
                    if (bus.funct3 == 3'b001) begin
                        dec_regwrite = 1'b1;
                        dec_regsel   = 2'b01;
                        for (int k = 0; k < NUM_CSR; k++) begin
                            if (bus.imm12 == 12'(CSR_BASE + 12'(CSR_STRIDE * k))) begin
                                dec_csr_we[k] = 1'b1;
                            end
                        end
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    // Divide sequencer: a divide holds EX for DIV_CYCLES cycles and stalls fetch/decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            bus.stall_FD <= 1'b0;
        end else if (bus.flush) begin
            state        <= IDLE;
            count        <= '0;
            bus.stall_FD <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dec_is_div) begin
                        state        <= BUSY;
                        count        <= CW'(DIV_CYCLES - 1);
                        bus.stall_FD <= 1'b1;
                    end
                end
                BUSY: begin
                    if (count == CW'(1)) begin
                        state        <= IDLE;
                        count        <= '0;
                        bus.stall_FD <= 1'b0;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    count        <= '0;
                    bus.stall_FD <= 1'b0;
                end
            endcase
        end
    end

    // EX stage register: loads decode when idle, holds while a divide is busy, bubbles on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.flush) begin
            bus.valid_EX        <= 1'b0;
            bus.regwrite_EX     <= 1'b0;
            bus.alusrc_EX       <= 2'b00;
            bus.regsel_EX       <= 2'b00;
            bus.aluop_EX        <= ALU_ADD;
            bus.div_unsigned_EX <= 1'b0;
            bus.illegal_EX      <= 1'b0;
            bus.csr_we_EX       <= '0;
        end else if (state == IDLE) begin
            bus.valid_EX        <= bus.instr_valid;
            bus.regwrite_EX     <= dec_regwrite;
            bus.alusrc_EX       <= dec_alusrc;
            bus.regsel_EX       <= dec_regsel;
            bus.aluop_EX        <= dec_aluop;
            bus.div_unsigned_EX <= dec_div_unsigned;
            bus.illegal_EX      <= dec_illegal;
            bus.csr_we_EX       <= dec_csr_we;
        end
    end

    // WB stage: a held divide only retires once, on the cycle after its last EX cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.regwrite_WB <= 1'b0;
            bus.regsel_WB   <= 2'b00;
        end else begin
            bus.regwrite_WB <= (state == BUSY) ? 1'b0 : bus.regwrite_EX;
            bus.regsel_WB   <= bus.regsel_EX;
        end
    end

endmodule
